// File: rtl/dm_row_scheduler.sv
// rtl/dm_row_scheduler.sv - frame sequencer for the disparity engine and its 7-row line buffers
//
// Streams reference/search pixel pairs into two circular BRAM line buffers
// (row r lives in slot r%ROWS) on BRAM port A. Starts the engine with go and
// holds it with busy until the 7x7 window rows for comp_row are resident.
// Counts engine done pulses to retire rows, free slots and end the frame.
//
// Optional feature macro: DM_SCHED_STATS_EN (adds stall_cycles/starve_rows).
//
// Ports:
//   clkb, reset                   clock, synchronous active-high reset
//   start                         pulse, begins a frame from IDLE
//   pix_valid/pix_ready           source handshake for pix_ref/pix_srch (12b)
//   ena_*/wea_*/addra_*/dina_*    BRAM port-A write (registered, 1 cycle after transfer)
//   go                            one-cycle engine start pulse
//   busy                          engine hold (level)
//   done                          engine per-pixel completion pulse
//   fifo_full                     output FIFO full, forces busy
//   comp_row                      row currently computed by the engine
//   frame_done                    one-cycle pulse when the last row retires
//   stall_cycles/starve_rows      (DM_SCHED_STATS_EN only) RUN stall counters
module dm_row_scheduler #(
    parameter int HRES      = 640,
    parameter int VRES      = 480,
    parameter int ROWS      = 7,
    parameter int COL_FIRST = 63,
    parameter int COL_LAST  = HRES - 3
) (
    input  logic        clkb,
    input  logic        reset,
    input  logic        start,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [11:0] pix_ref,
    input  logic [11:0] pix_srch,
    output logic        ena_ref,
    output logic        ena_srch,
    output logic [3:0]  wea_ref,
    output logic [3:0]  wea_srch,
    output logic [31:0] addra_ref,
    output logic [31:0] addra_srch,
    output logic [31:0] dina_ref,
    output logic [31:0] dina_srch,
    output logic        go,
    output logic        busy,
    input  logic        done,
    input  logic        fifo_full,
    output logic [11:0] comp_row,
    output logic        frame_done
`ifdef DM_SCHED_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] starve_rows
`endif
);

    localparam logic [11:0] COL_MAX   = 12'(HRES - 1);
    localparam logic [11:0] VRES_W    = 12'(VRES);
    localparam logic [11:0] LAST_ROW  = 12'(VRES - 4);
    localparam logic [11:0] PIX_LAST  = 12'(COL_LAST - COL_FIRST);
    localparam logic [3:0]  ROWS_W    = 4'(ROWS);
    localparam logic [31:0] STRIDE    = 32'(HRES);
    localparam logic [31:0] BASE_LAST = 32'((ROWS - 1) * HRES);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

    state_t      state, state_nxt;
    logic [11:0] in_row, in_col, pix_cnt;
    logic [3:0]  slots_used;
    logic [31:0] wr_base;          // (in_row % ROWS) * HRES, tracked incrementally
    logic        wr_en;
    logic [31:0] wr_addr, din_ref_q, din_srch_q;
    logic        xfer, row_end, retire, row_ready, last_row;

    assign xfer      = pix_valid & pix_ready;
    assign row_end   = xfer & (in_col == COL_MAX);
    assign retire    = (state == S_RUN) & done & (pix_cnt == PIX_LAST);
    assign last_row  = (comp_row == LAST_ROW);
    // Window for comp_row needs rows comp_row-3..comp_row+3 fully written.
    assign row_ready = (in_row >= comp_row + 12'd4) | (in_row == VRES_W);

    assign ena_ref    = wr_en;
    assign ena_srch   = wr_en;
    assign wea_ref    = {4{wr_en}};
    assign wea_srch   = {4{wr_en}};
    assign addra_ref  = wr_addr;
    assign addra_srch = wr_addr;
    assign dina_ref   = din_ref_q;
    assign dina_srch  = din_srch_q;

    always_ff @(posedge clkb) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FILL;
            end
            S_FILL: begin
                pix_ready = (slots_used < ROWS_W) & (in_row < VRES_W);
                if (slots_used == ROWS_W) state_nxt = S_RUN;
            end
            S_RUN: begin
                pix_ready = (slots_used < ROWS_W) & (in_row < VRES_W);
                busy      = ~row_ready | fifo_full;
                if (retire && last_row) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clkb) begin
        if (reset) begin
            go         <= 1'b0;
            frame_done <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= 32'd0;
            din_ref_q  <= 32'd0;
            din_srch_q <= 32'd0;
            in_row     <= 12'd0;
            in_col     <= 12'd0;
            slots_used <= 4'd0;
            pix_cnt    <= 12'd0;
            comp_row   <= 12'd3;
            wr_base    <= 32'd0;
        end else begin
            go         <= (state == S_FILL) && (slots_used == ROWS_W);
            frame_done <= (state == S_FLUSH);
            wr_en      <= xfer;
            if (xfer) begin
                wr_addr    <= wr_base + {20'd0, in_col};
                din_ref_q  <= {20'd0, pix_ref};
                din_srch_q <= {20'd0, pix_srch};
            end
            if (state == S_FLUSH) begin
                in_row     <= 12'd0;
                in_col     <= 12'd0;
                slots_used <= 4'd0;
                pix_cnt    <= 12'd0;
                comp_row   <= 12'd3;
                wr_base    <= 32'd0;
            end else begin
                if (xfer) begin
                    if (in_col == COL_MAX) begin
                        in_col  <= 12'd0;
                        in_row  <= in_row + 12'd1;
                        wr_base <= (wr_base == BASE_LAST) ? 32'd0 : wr_base + STRIDE;
                    end else begin
                        in_col <= in_col + 12'd1;
                    end
                end
                // A row landing and a row retiring in the same cycle cancel out.
                case ({row_end, retire})
                    2'b10:   slots_used <= slots_used + 4'd1;
                    2'b01:   slots_used <= slots_used - 4'd1;
                    default: ;
                endcase
                // done is counted even while busy: the engine may finish an in-flight pixel.
                if (state == S_RUN && done) begin
                    if (pix_cnt == PIX_LAST) begin
                        pix_cnt  <= 12'd0;
                        comp_row <= comp_row + 12'd1;
                    end else begin
                        pix_cnt <= pix_cnt + 12'd1;
                    end
                end
            end
        end
    end

`ifdef DM_SCHED_STATS_EN
    always_ff @(posedge clkb) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            starve_rows  <= 16'd0;
        end else if (state == S_IDLE && start) begin
            stall_cycles <= 32'd0;
            starve_rows  <= 16'd0;
        end else if (state == S_RUN && busy) begin
            stall_cycles <= stall_cycles + 32'd1;
            if (!row_ready) starve_rows <= starve_rows + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dm_row_scheduler.sv
// tb/tb_dm_row_scheduler.sv - directed self-checking bench for dm_row_scheduler (HRES=70, VRES=10)
module tb_dm_row_scheduler;

    logic        clkb = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [11:0] pix_ref = 12'd0;
    logic [11:0] pix_srch = 12'd0;
    logic        ena_ref, ena_srch;
    logic [3:0]  wea_ref, wea_srch;
    logic [31:0] addra_ref, addra_srch, dina_ref, dina_srch;
    logic        go, busy;
    logic        done = 1'b0;
    logic        fifo_full = 1'b0;
    logic [11:0] comp_row;
    logic        frame_done;

    int checks = 0;
    int failures = 0;
    int tx_k = 0;
    int wr_k = 0;
    int cyc_n = 0;
    int go_cnt = 0;
    int go_cyc = 0;
    int last_wr_cyc = 0;
    int fd_cnt = 0;
    int dn_run = 0;

    dm_row_scheduler #(.HRES(70), .VRES(10)) dut (
        .clkb(clkb), .reset(reset), .start(start),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_ref(pix_ref), .pix_srch(pix_srch),
        .ena_ref(ena_ref), .ena_srch(ena_srch),
        .wea_ref(wea_ref), .wea_srch(wea_srch),
        .addra_ref(addra_ref), .addra_srch(addra_srch),
        .dina_ref(dina_ref), .dina_srch(dina_srch),
        .go(go), .busy(busy), .done(done), .fifo_full(fifo_full),
        .comp_row(comp_row), .frame_done(frame_done)
    );

    always #5 clkb = ~clkb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: present the next pixel, advance, then sample at the falling edge.
    task automatic cyc();
        logic [11:0] k12;
        logic [31:0] exp_addr;
        k12 = 12'(tx_k);
        pix_ref  = k12;
        pix_srch = ~k12;
        if (!reset && pix_valid && pix_ready) tx_k++;
        @(posedge clkb);
        @(negedge clkb);
        cyc_n++;
        if (go === 1'b1) begin
            go_cnt++;
            go_cyc = cyc_n;
        end
        if (frame_done === 1'b1) fd_cnt++;
        if (ena_ref === 1'b1) begin
            k12 = 12'(wr_k);
            exp_addr = 32'(((wr_k / 70) % 7) * 70 + (wr_k % 70));
            chk("wr_addr_ref", addra_ref, exp_addr);
            chk("wr_addr_srch", addra_srch, exp_addr);
            chk("wr_din_ref", dina_ref, {20'd0, k12});
            chk("wr_din_srch", dina_srch, {20'd0, ~k12});
            chk("wr_en_we", {23'd0, ena_srch, wea_ref, wea_srch}, {23'd0, 1'b1, 8'hFF});
            wr_k++;
            last_wr_cyc = cyc_n;
        end
    endtask

    task automatic run_fill();
        tx_k = 0;
        wr_k = 0;
        go_cnt = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        pix_valid = 1'b1;
        for (int i = 0; i < 600 && go_cnt == 0; i++) cyc();
        cyc();
        cyc();
        chk("go_once", go_cnt, 1);
        chk("go_after_fill", go_cyc, last_wr_cyc + 1);
        chk("fill_writes", wr_k, 490);
        chk("ready_when_full", pix_ready, 0);
        chk("go_low", go, 0);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        cyc();
        cyc();
        chk("rst_busy", busy, 1);
        chk("rst_comp_row", comp_row, 3);
        chk("rst_ready", pix_ready, 0);
        chk("rst_go_fd", {go, frame_done}, 0);
        chk("rst_en_we", {ena_ref, ena_srch, wea_ref, wea_srch}, 0);
        chk("rst_addr", addra_ref, 0);
        chk("rst_din", dina_ref, 0);
        reset = 1'b0;
        cyc();

        // 1: fill rows 0..6 with source always valid
        run_fill();
        chk("run_busy_ready", busy, 0);

        // 2: retire row 3, stream row 7 into slot 0
        pix_valid = 1'b0;
        done = 1'b1;
        repeat (5) cyc();
        done = 1'b0;
        chk("s2_comp_row", comp_row, 4);
        chk("s2_ready", pix_ready, 1);
        chk("s2_busy_wait", busy, 1);
        pix_valid = 1'b1;
        repeat (69) cyc();
        chk("s2_busy_row7_partial", busy, 1);
        cyc();
        chk("s2_row7_writes", wr_k, 560);
        chk("s2_busy_row7_done", busy, 0);
        chk("s2_ready_full", pix_ready, 0);

        // 3: fifo_full forces busy; done still counted
        pix_valid = 1'b0;
        fifo_full = 1'b1;
        cyc();
        chk("s3_busy_full", busy, 1);
        done = 1'b1;
        cyc();
        done = 1'b0;
        fifo_full = 1'b0;
        cyc();
        chk("s3_busy_release", busy, 0);
        done = 1'b1;
        repeat (4) cyc();
        done = 1'b0;
        chk("s3_comp_row", comp_row, 5);
        chk("s3_busy_starve", busy, 1);
        chk("s3_ready", pix_ready, 1);

        // 5: row 8 completes in the same cycle as the row-5 retire
        done = 1'b1;
        repeat (4) cyc();
        done = 1'b0;
        pix_valid = 1'b1;
        repeat (69) cyc();
        done = 1'b1;
        cyc();
        done = 1'b0;
        chk("s5_comp_row", comp_row, 6);
        chk("s5_ready_slots", pix_ready, 1);
        chk("s5_busy", busy, 1);
        repeat (70) cyc();
        pix_valid = 1'b0;
        chk("s5_writes", wr_k, 700);
        chk("s5_ready_eof", pix_ready, 0);
        chk("s5_busy_eof", busy, 0);
        fd_cnt = 0;
        done = 1'b1;
        repeat (5) cyc();
        done = 1'b0;
        chk("flush_busy", busy, 1);
        chk("flush_no_fd", frame_done, 0);
        cyc();
        chk("flush_fd", frame_done, 1);
        chk("flush_comp_row", comp_row, 3);
        cyc();
        chk("flush_fd_once", fd_cnt, 1);

        // 4: full frame, continuous source, done every third cycle
        tx_k = 0;
        wr_k = 0;
        go_cnt = 0;
        fd_cnt = 0;
        dn_run = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        pix_valid = 1'b1;
        for (int i = 0; i < 1000 && fd_cnt == 0; i++) begin
            done = (i % 3 == 0);
            if (go_cnt > 0 && done) dn_run++;
            cyc();
        end
        done = 1'b0;
        chk("s4_frame_done", fd_cnt, 1);
        chk("s4_done_count", dn_run, 20);
        chk("s4_comp_row", comp_row, 3);
        chk("s4_idle_ready", pix_ready, 0);
        chk("s4_idle_busy", busy, 1);
        repeat (3) cyc();
        chk("s4_fd_once", fd_cnt, 1);
        chk("s4_go_once", go_cnt, 1);

        // 4/6: second start reproduces the fill, then reset mid-RUN
        run_fill();
        done = 1'b1;
        repeat (10) cyc();
        done = 1'b0;
        chk("s6_comp_row", comp_row, 5);
        reset = 1'b1;
        cyc();
        chk("s6_rst_en", {ena_ref, ena_srch, wea_ref, wea_srch}, 0);
        chk("s6_rst_busy", busy, 1);
        chk("s6_rst_comp_row", comp_row, 3);
        chk("s6_rst_ready", pix_ready, 0);
        chk("s6_rst_pulses", {go, frame_done}, 0);
        chk("s6_rst_addr", addra_ref, 0);
        chk("s6_rst_din", dina_ref, 0);
        reset = 1'b0;
        cyc();
        chk("s6_idle_no_write", ena_ref, 0);
        run_fill();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
